// File: rtl/can_frame_header_decoder.sv
// CAN arbitration/control field decoder.
// Votes the sampled bus bit, removes and checks stuff bits, and decodes
// base/extended ID, RTR, IDE, FDF/BRS/ESI (optional FD) and DLC, together
// with the resulting payload byte count.
module can_frame_header_decoder #(
    parameter int SAMPLES_PER_BIT = 3,
    parameter int FD_SUPPORT      = 0,
    parameter int STUFF_LEN       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        dIn,
    input  logic        samplePulse,
    output logic [28:0] canId,
    output logic        ide,
    output logic        rtr,
    output logic        fdf,
    output logic        brs,
    output logic        esi,
    output logic [3:0]  dlc,
    output logic [6:0]  byteCount,
    output logic        headerDone,
    output logic        stuffError,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, BASE_ID, RTR_SRR, IDE_BIT, EXT_ID, EXT_RTR, FDF_BIT, SKIP, DLC_F, DONE, ERROR
    } state_t;

    localparam logic [1:0] VOTE_LAST = 2'(SAMPLES_PER_BIT - 1);
    localparam logic [3:0] VOTE_SPB  = 4'(SAMPLES_PER_BIT);
    localparam logic [2:0] RUN_MAX   = 3'(STUFF_LEN);
    localparam logic       FD_EN     = (FD_SUPPORT != 0);

    // Majority of the collected samples; degenerates to the sample itself for one sample per bit.
    function automatic logic vote_bit(input logic [1:0] ones, input logic d);
        logic [2:0] total;
        total = {1'b0, ones} + {2'b00, d};
        return ({total, 1'b0} > VOTE_SPB);
    endfunction

    // Payload size from DLC; FD lengths only apply to FD frames.
    function automatic logic [6:0] dlc_to_bytes(input logic [3:0] code, input logic fd);
        logic [6:0] n;
        if (code <= 4'd8) begin
            n = {3'b000, code};
        end else if (!fd) begin
            n = 7'd8;
        end else begin
            case (code)
                4'd9:    n = 7'd12;
                4'd10:   n = 7'd16;
                4'd11:   n = 7'd20;
                4'd12:   n = 7'd24;
                4'd13:   n = 7'd32;
                4'd14:   n = 7'd48;
                default: n = 7'd64;
            endcase
        end
        return n;
    endfunction

    logic [1:0]  vote_cnt_q, ones_q;
    logic        bit_q, bit_stb_q;
    state_t      state_q, state_d;
    logic        last_bit_q, last_bit_d;
    logic [2:0]  run_len_q, run_len_d;
    logic [4:0]  fld_cnt_q, fld_cnt_d;
    logic [1:0]  skip_q, skip_d;
    logic [28:0] id_q, id_d;
    logic        ide_q, ide_d, rtr_q, rtr_d, fdf_q, fdf_d, brs_q, brs_d, esi_q, esi_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [6:0]  byte_cnt_q, byte_cnt_d;
    logic        done_q, err_q, busy_q;
    logic        data_stb_s, fdf_bit_s;

    // Sample voting: accumulate strobes, register the voted bit and pulse bit_stb_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vote_cnt_q <= 2'd0;
            ones_q     <= 2'd0;
            bit_q      <= 1'b0;
            bit_stb_q  <= 1'b0;
        end else if (!enable) begin
            vote_cnt_q <= 2'd0;
            ones_q     <= 2'd0;
            bit_stb_q  <= 1'b0;
        end else if (samplePulse) begin
            if (vote_cnt_q == VOTE_LAST) begin
                bit_q      <= vote_bit(ones_q, dIn);
                bit_stb_q  <= 1'b1;
                vote_cnt_q <= 2'd0;
                ones_q     <= 2'd0;
            end else begin
                vote_cnt_q <= vote_cnt_q + 2'd1;
                ones_q     <= ones_q + {1'b0, dIn};
                bit_stb_q  <= 1'b0;
            end
        end else begin
            bit_stb_q <= 1'b0;
        end
    end

    // Next-state: destuffing, field sequencing and field capture.
    always_comb begin
        state_d    = state_q;
        last_bit_d = last_bit_q;
        run_len_d  = run_len_q;
        fld_cnt_d  = fld_cnt_q;
        skip_d     = skip_q;
        id_d       = id_q;
        ide_d      = ide_q;
        rtr_d      = rtr_q;
        fdf_d      = fdf_q;
        brs_d      = brs_q;
        esi_d      = esi_q;
        dlc_d      = dlc_q;
        data_stb_s = 1'b0;
        fdf_bit_s  = bit_q & FD_EN;

        if (!enable) begin
            state_d = IDLE;
        end else if (!bit_stb_q) begin
            state_d = state_q;
        end else if (state_q == IDLE) begin
            if (!bit_q) begin
                // Start of frame: fresh run tracking and cleared fields.
                state_d    = BASE_ID;
                last_bit_d = 1'b0;
                run_len_d  = 3'd1;
                fld_cnt_d  = 5'd0;
                skip_d     = 2'd0;
                id_d       = 29'd0;
                ide_d      = 1'b0;
                rtr_d      = 1'b0;
                fdf_d      = 1'b0;
                brs_d      = 1'b0;
                esi_d      = 1'b0;
                dlc_d      = 4'd0;
            end else begin
                state_d = IDLE;
            end
        end else if (state_q == DONE || state_q == ERROR) begin
            state_d = state_q;
        end else if (run_len_q == RUN_MAX) begin
            // This bit must be a stuff bit of opposite polarity.
            if (bit_q != last_bit_q) begin
                last_bit_d = bit_q;
                run_len_d  = 3'd1;
            end else begin
                state_d = ERROR;
            end
        end else begin
            data_stb_s = 1'b1;
            if (bit_q == last_bit_q) begin
                run_len_d = run_len_q + 3'd1;
            end else begin
                run_len_d  = 3'd1;
                last_bit_d = bit_q;
            end
        end

        if (data_stb_s) begin
            case (state_q)
                BASE_ID: begin
                    id_d = {id_q[27:0], bit_q};
                    if (fld_cnt_q == 5'd10) begin
                        fld_cnt_d = 5'd0;
                        state_d   = RTR_SRR;
                    end else begin
                        fld_cnt_d = fld_cnt_q + 5'd1;
                    end
                end
                RTR_SRR: begin
                    rtr_d   = bit_q;
                    state_d = IDE_BIT;
                end
                IDE_BIT: begin
                    ide_d   = bit_q;
                    state_d = bit_q ? EXT_ID : FDF_BIT;
                end
                EXT_ID: begin
                    id_d = {id_q[27:0], bit_q};
                    if (fld_cnt_q == 5'd17) begin
                        fld_cnt_d = 5'd0;
                        state_d   = EXT_RTR;
                    end else begin
                        fld_cnt_d = fld_cnt_q + 5'd1;
                    end
                end
                EXT_RTR: begin
                    rtr_d   = bit_q;
                    state_d = FDF_BIT;
                end
                FDF_BIT: begin
                    fdf_d = fdf_bit_s;
                    if (fdf_bit_s) begin
                        rtr_d   = 1'b0;
                        skip_d  = 2'd3;
                        state_d = SKIP;
                    end else if (ide_q) begin
                        skip_d  = 2'd1;
                        state_d = SKIP;
                    end else begin
                        state_d = DLC_F;
                    end
                end
                SKIP: begin
                    // FD skip order is res, BRS, ESI.
                    if (fdf_q && skip_q == 2'd2) begin
                        brs_d = bit_q;
                    end else if (fdf_q && skip_q == 2'd1) begin
                        esi_d = bit_q;
                    end else begin
                        brs_d = brs_q;
                    end
                    skip_d  = skip_q - 2'd1;
                    state_d = (skip_q == 2'd1) ? DLC_F : SKIP;
                end
                DLC_F: begin
                    dlc_d = {dlc_q[2:0], bit_q};
                    if (fld_cnt_q == 5'd3) begin
                        fld_cnt_d = 5'd0;
                        state_d   = DONE;
                    end else begin
                        fld_cnt_d = fld_cnt_q + 5'd1;
                    end
                end
                default: state_d = state_q;
            endcase
        end else begin
            fld_cnt_d = fld_cnt_d;
        end

        byte_cnt_d = dlc_to_bytes(dlc_d, fdf_d);
    end

    // State, field and status registers; status flags follow the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_bit_q <= 1'b0;
            run_len_q  <= 3'd0;
            fld_cnt_q  <= 5'd0;
            skip_q     <= 2'd0;
            id_q       <= 29'd0;
            ide_q      <= 1'b0;
            rtr_q      <= 1'b0;
            fdf_q      <= 1'b0;
            brs_q      <= 1'b0;
            esi_q      <= 1'b0;
            dlc_q      <= 4'd0;
            byte_cnt_q <= 7'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_bit_q <= last_bit_d;
            run_len_q  <= run_len_d;
            fld_cnt_q  <= fld_cnt_d;
            skip_q     <= skip_d;
            id_q       <= id_d;
            ide_q      <= ide_d;
            rtr_q      <= rtr_d;
            fdf_q      <= fdf_d;
            brs_q      <= brs_d;
            esi_q      <= esi_d;
            dlc_q      <= dlc_d;
            byte_cnt_q <= byte_cnt_d;
            done_q     <= (state_d == DONE);
            err_q      <= (state_d == ERROR);
            busy_q     <= !(state_d == IDLE || state_d == DONE || state_d == ERROR);
        end
    end

    assign canId      = id_q;
    assign ide        = ide_q;
    assign rtr        = rtr_q;
    assign fdf        = fdf_q;
    assign brs        = brs_q;
    assign esi        = esi_q;
    assign dlc        = dlc_q;
    assign byteCount  = byte_cnt_q;
    assign headerDone = done_q;
    assign stuffError = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_can_frame_header_decoder.sv
// Bench for can_frame_header_decoder: three instances (classic 1-sample,
// FD 1-sample, classic 3-sample) share the inputs; each scenario queues the
// header it expects and compares it when the selected instance finishes.
module tb_can_frame_header_decoder;

    typedef struct packed {
        logic [28:0] id;
        logic        ide, rtr, fdf, brs, esi;
        logic [3:0]  dlc;
        logic [6:0]  bc;
        logic        hd, se;
    } hdr_t;

    logic clk = 1'b0;
    logic reset, enable, dIn, samplePulse;
    logic [28:0] can_id_s [3];
    logic        ide_s [3], rtr_s [3], fdf_s [3], brs_s [3], esi_s [3];
    logic [3:0]  dlc_s [3];
    logic [6:0]  bc_s [3];
    logic        hd_s [3], se_s [3], busy_s [3];

    int   n_vec = 0;
    int   n_fail = 0;
    logic tx_q[$];
    hdr_t sb_q[$];
    int   sel_q[$];

    always #5 clk = ~clk;

    can_frame_header_decoder #(.SAMPLES_PER_BIT(1), .FD_SUPPORT(0), .STUFF_LEN(5)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .dIn(dIn), .samplePulse(samplePulse),
        .canId(can_id_s[0]), .ide(ide_s[0]), .rtr(rtr_s[0]), .fdf(fdf_s[0]), .brs(brs_s[0]),
        .esi(esi_s[0]), .dlc(dlc_s[0]), .byteCount(bc_s[0]), .headerDone(hd_s[0]),
        .stuffError(se_s[0]), .busy(busy_s[0]));

    can_frame_header_decoder #(.SAMPLES_PER_BIT(1), .FD_SUPPORT(1), .STUFF_LEN(5)) dut_f (
        .clk(clk), .reset(reset), .enable(enable), .dIn(dIn), .samplePulse(samplePulse),
        .canId(can_id_s[1]), .ide(ide_s[1]), .rtr(rtr_s[1]), .fdf(fdf_s[1]), .brs(brs_s[1]),
        .esi(esi_s[1]), .dlc(dlc_s[1]), .byteCount(bc_s[1]), .headerDone(hd_s[1]),
        .stuffError(se_s[1]), .busy(busy_s[1]));

    can_frame_header_decoder #(.SAMPLES_PER_BIT(3), .FD_SUPPORT(0), .STUFF_LEN(5)) dut_v (
        .clk(clk), .reset(reset), .enable(enable), .dIn(dIn), .samplePulse(samplePulse),
        .canId(can_id_s[2]), .ide(ide_s[2]), .rtr(rtr_s[2]), .fdf(fdf_s[2]), .brs(brs_s[2]),
        .esi(esi_s[2]), .dlc(dlc_s[2]), .byteCount(bc_s[2]), .headerDone(hd_s[2]),
        .stuffError(se_s[2]), .busy(busy_s[2]));

    // Builds the on-wire bit sequence (SOF through DLC) with stuff bits inserted.
    task automatic build_frame(input logic [28:0] id, input logic ide, input logic rtr,
                               input logic fd_fmt, input logic brs, input logic esi,
                               input logic r0bit, input logic [3:0] dlc);
        logic raw[$];
        logic last;
        int   run;
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(ide ? id[18+i] : id[i]);
        if (!ide) begin
            raw.push_back(rtr);
            raw.push_back(1'b0);
        end else begin
            raw.push_back(1'b1);
            raw.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw.push_back(id[i]);
            raw.push_back(rtr);
        end
        if (fd_fmt) begin
            raw.push_back(1'b1);
            raw.push_back(1'b0);
            raw.push_back(brs);
            raw.push_back(esi);
        end else begin
            raw.push_back(r0bit);
            if (ide) raw.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        tx_q.delete();
        last = 1'b1;
        run  = 0;
        foreach (raw[i]) begin
            if (run == 5) begin
                tx_q.push_back(~last);
                last = ~last;
                run  = 1;
            end
            tx_q.push_back(raw[i]);
            if (raw[i] == last) begin
                run++;
            end else begin
                run  = 1;
                last = raw[i];
            end
        end
    endtask

    // Drives the first n queued bits, spb strobes each; optionally corrupts one sample per bit.
    // Returns headerDone of instance sel one and two cycles after the final strobe.
    task automatic send_bits(input int n, input int spb, input bit corrupt, input int sel,
                             output logic hd_mid, output logic hd_late);
        bit last_pulse;
        hd_mid  = 1'b0;
        hd_late = 1'b0;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < spb; k++) begin
                dIn = tx_q[b] ^ (corrupt && (k == (b % 3)));
                samplePulse = 1'b1;
                @(posedge clk); #1;
                samplePulse = 1'b0;
                last_pulse = (b == n - 1) && (k == spb - 1);
                if (last_pulse) hd_mid = hd_s[sel];
                @(posedge clk); #1;
                if (last_pulse) hd_late = hd_s[sel];
            end
        end
        dIn = 1'b1;
    endtask

    // Pops the next expectation and waits (bounded) for its instance to finish or fail.
    task automatic collect(output hdr_t exp, output hdr_t got, output logic to);
        int s;
        int i;
        exp = sb_q.pop_front();
        s   = sel_q.pop_front();
        to  = 1'b1;
        i   = 0;
        while (i < 400 && to) begin
            if (hd_s[s] || se_s[s]) to = 1'b0;
            else begin
                @(posedge clk); #1;
            end
            i++;
        end
        got = {can_id_s[s], ide_s[s], rtr_s[s], fdf_s[s], brs_s[s], esi_s[s],
               dlc_s[s], bc_s[s], hd_s[s], se_s[s]};
    endtask

    task automatic rearm();
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        hdr_t got;
        logic m, l;
        reset = 1'b1; enable = 1'b0; dIn = 1'b1; samplePulse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            got = {can_id_s[s], ide_s[s], rtr_s[s], fdf_s[s], brs_s[s], esi_s[s],
                   dlc_s[s], bc_s[s], hd_s[s], se_s[s]};
            n_vec++;
            if (got !== 47'd0 || busy_s[s] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %h busy %b, expected 0 busy 0", s, got, busy_s[s]);
            end
        end
        reset = 1'b0;
        rearm();
        build_frame(29'h2A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
        send_bits(8, 1, 1'b0, 0, m, l);
        n_vec++;
        if (busy_s[0] !== 1'b1 || can_id_s[0] !== 29'h2A) begin
            n_fail++;
            $display("FAIL midframe_busy: got busy %b id %h, expected busy 1 id 2a", busy_s[0], can_id_s[0]);
        end
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if (busy_s[0] !== 1'b0 || can_id_s[0] !== 29'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got busy %b id %h, expected busy 0 id 0", busy_s[0], can_id_s[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_classic_base();
        hdr_t e, g;
        logic to, m, l;
        rearm();
        build_frame(29'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        sb_q.push_back({29'h0, 5'b00000, 4'd0, 7'd0, 1'b1, 1'b0}); sel_q.push_back(0);
        sb_q.push_back({29'h0, 5'b00000, 4'd0, 7'd0, 1'b1, 1'b0}); sel_q.push_back(1);
        send_bits(tx_q.size(), 1, 1'b0, 0, m, l);
        n_vec++;
        if (m !== 1'b0 || l !== 1'b1) begin
            n_fail++;
            $display("FAIL done_latency: got +1=%b +2=%b, expected +1=0 +2=1", m, l);
        end
        for (int k = 0; k < 2; k++) begin
            collect(e, g, to);
            n_vec++;
            if (to || g !== e) begin
                n_fail++;
                $display("FAIL classic_base[%0d]: got %h timeout %b, expected %h", k, g, to, e);
            end
        end
    endtask

    task automatic test_extended();
        hdr_t e, g;
        logic to, m, l;
        rearm();
        build_frame(29'h12345678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
        sb_q.push_back({29'h12345678, 5'b11000, 4'd8, 7'd8, 1'b1, 1'b0}); sel_q.push_back(0);
        send_bits(tx_q.size(), 1, 1'b0, 0, m, l);
        collect(e, g, to);
        n_vec++;
        if (to || g !== e) begin
            n_fail++;
            $display("FAIL extended: got %h timeout %b, expected %h", g, to, e);
        end
    endtask

    task automatic test_fd();
        hdr_t e, g;
        logic to, m, l;
        // FD base frame on the FD instance: 0x7FF, BRS=1, ESI=0, DLC 13.
        rearm();
        build_frame(29'h7FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd13);
        sb_q.push_back({29'h7FF, 5'b00110, 4'd13, 7'd32, 1'b1, 1'b0}); sel_q.push_back(1);
        send_bits(tx_q.size(), 1, 1'b0, 1, m, l);
        collect(e, g, to);
        n_vec++;
        if (to || g !== e) begin
            n_fail++;
            $display("FAIL fd_base: got %h timeout %b, expected %h", g, to, e);
        end
        // Same ID with FDF slot recessive and DLC 13 on the classic instance.
        rearm();
        build_frame(29'h7FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd13);
        sb_q.push_back({29'h7FF, 5'b00000, 4'd13, 7'd8, 1'b1, 1'b0}); sel_q.push_back(0);
        send_bits(tx_q.size(), 1, 1'b0, 0, m, l);
        collect(e, g, to);
        n_vec++;
        if (to || g !== e) begin
            n_fail++;
            $display("FAIL classic_dlc13: got %h timeout %b, expected %h", g, to, e);
        end
        // FD extended frame with RRS set (rtr forced low), ESI=1, DLC 9.
        rearm();
        build_frame(29'h0ABCDEF1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
        sb_q.push_back({29'h0ABCDEF1, 5'b10101, 4'd9, 7'd12, 1'b1, 1'b0}); sel_q.push_back(1);
        send_bits(tx_q.size(), 1, 1'b0, 1, m, l);
        collect(e, g, to);
        n_vec++;
        if (to || g !== e) begin
            n_fail++;
            $display("FAIL fd_extended: got %h timeout %b, expected %h", g, to, e);
        end
    endtask

    task automatic test_stuff_error();
        hdr_t e, g;
        logic to, m, l;
        rearm();
        tx_q.delete();
        repeat (6) tx_q.push_back(1'b0);
        sb_q.push_back({29'h0, 5'b00000, 4'd0, 7'd0, 1'b0, 1'b1}); sel_q.push_back(0);
        send_bits(6, 1, 1'b0, 0, m, l);
        collect(e, g, to);
        n_vec++;
        if (to || g !== e || busy_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stuff_error: got %h busy %b timeout %b, expected %h busy 0", g, busy_s[0], to, e);
        end
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (se_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || hd_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stuff_error_clear: got se %b busy %b hd %b, expected 0 0 0", se_s[0], busy_s[0], hd_s[0]);
        end
    endtask

    task automatic test_vote();
        hdr_t e, g;
        logic to, m, l;
        rearm();
        build_frame(29'h123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
        sb_q.push_back({29'h123, 5'b00000, 4'd5, 7'd5, 1'b1, 1'b0}); sel_q.push_back(2);
        send_bits(tx_q.size(), 3, 1'b1, 2, m, l);
        collect(e, g, to);
        n_vec++;
        if (to || g !== e) begin
            n_fail++;
            $display("FAIL vote_3x: got %h timeout %b, expected %h", g, to, e);
        end
    endtask

    task automatic test_abort();
        hdr_t e, g;
        logic to, m, l;
        rearm();
        build_frame(29'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
        send_bits(20, 1, 1'b0, 0, m, l);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (busy_s[0] !== 1'b0 || hd_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy %b hd %b, expected 0 0", busy_s[0], hd_s[0]);
        end
        enable = 1'b1;
        build_frame(29'h055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        sb_q.push_back({29'h055, 5'b00000, 4'd2, 7'd2, 1'b1, 1'b0}); sel_q.push_back(0);
        send_bits(tx_q.size(), 1, 1'b0, 0, m, l);
        collect(e, g, to);
        n_vec++;
        if (to || g !== e) begin
            n_fail++;
            $display("FAIL abort_restart: got %h timeout %b, expected %h", g, to, e);
        end
    endtask

    initial begin
        test_reset();
        test_classic_base();
        test_extended();
        test_fd();
        test_stuff_error();
        test_vote();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
